clock_divider_bank: RTL and testbench
=====================================

Name: clock_divider_bank

Overview:
- Parametrised multi-channel programmable clock generator; successor to the single fixed-rate Clock source.
- Derives CHANNELS independent divided clocks from one system clock.
- Each channel has its own programmable period and high time, updated glitch-free through a valid/ready config port.
- Feeds clock-enables and slow strobes to peripherals and testbenches.

Parameters:
CHANNELS, 4, number of independent divider channels (1..16)
DIV_W, 8, width of period/high-time fields
DEFAULT_PERIOD, 10, period loaded into every channel at reset (clamped to >=2)

Ports:
clock  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
enable  in  CHANNELS  per-channel run enable
cfg_valid  in  1  config request
cfg_ready  out  1  config accepted when valid&&ready
cfg_chan  in  max(1,$clog2(CHANNELS))  target channel
cfg_period  in  DIV_W  new period in cycles
cfg_high  in  DIV_W  new high time in cycles
sync_restart  in  1  restart all enabled channels in phase
clk_out  out  CHANNELS  divided clock outputs, registered
tick  out  CHANNELS  one-cycle pulse on last cycle of each period, registered

Behaviour:
- Reset (async assert, sync release): cnt=0; period=DEFAULT_PERIOD; high=DEFAULT_PERIOD/2; pending=0; clk_out=0; tick=0.
- Period values P<2 are clamped to 2.
- Per channel, counter cnt runs 0..P-1 and wraps to 0.
  - In the cycle cnt==k: clk_out=(k<H) and tick=(k==P-1).
  - Both outputs come from flops; no combinational path from inputs.
- H=0 -> clk_out constant 0. H>=P -> constant 1.
- tick still pulses once per period in both of those cases.
- enable[i] low: cnt held at 0; clk_out[i]=0; tick[i]=0.
- First cycle after enable rises: cnt=0, so clk_out=(H>0).
- Config handshake:
  - cfg_ready = !pending[cfg_chan] (combinational on cfg_chan).
  - On accept: {period,high} are stored in the channel's shadow register and pending is set.
  - cfg_chan >= CHANNELS: cfg_ready=1, request is accepted and discarded.
- Pending shadow is applied at the next period boundary:
  - if enabled: the cycle cnt wraps P-1 -> 0;
  - if disabled: the next clock edge.
  - The new period takes effect from cnt=0; pending clears the same edge.
  - An in-flight period is never truncated or stretched, so there are no glitches.
- sync_restart:
  - Every enabled channel loads cnt=0 on the next edge.
  - Any pending shadow is applied on that same edge.
  - No tick is issued for the truncated period.
- Priority per channel: reset_n > enable low > sync_restart > natural wrap > count.
- Config accept and apply in the same cycle on the same channel is not possible: ready is low while pending.
- Counter width is DIV_W. Comparisons are unsigned, so no overflow.

Optional Feature:
- Macro: CLOCK_DIVIDER_PERIOD_COUNT_EN.
- Defined:
  - Adds output port period_count [CHANNELS*16].
  - Each channel has a 16-bit counter that increments on every tick and wraps 0xFFFF -> 0.
  - The counter is reset to 0 by reset_n and held while enable is low; sync_restart does not clear it.
- Undefined: port and counters are absent; all other behaviour is identical.

Decomposition:
- Package clock_divider_pkg:
  - DIV_W default and the MIN_PERIOD=2 constant;
  - typedef div_cfg_t {period, high};
  - clamp function for the period.
- Sub-module clock_divider_channel (one generated per channel):
  - holds cnt, active cfg, shadow cfg, pending, clk_out/tick flops and the optional period counter.
- Top level holds the cfg_chan decode, the cfg_ready mux and sync_restart fan-out.

Test Plan:
- Reset release, enable[0]=1, defaults (P=10,H=5) -> clk_out[0] high 5 / low 5 cycles repeating; tick[0] on every 10th cycle.
- Running P=10: write ch0 P=4,H=1 mid-period -> current 10-cycle period completes unchanged, then 1-high/3-low; cfg_ready low for ch0 until applied, high for ch1 meanwhile.
- Edge values: P=0 -> behaves as P=2; H=0 -> clk_out stuck 0 with tick every P cycles; H=12,P=6 -> stuck 1 with tick every 6.
- Channels 0..3 with P=3,5,7,9 running: pulse sync_restart -> all show cnt=0 next cycle, clk_out all 1, no tick that cycle.
- Assert reset_n low mid-period with a config pending -> outputs 0 immediately (async), pending lost, defaults restored after release.
- With CLOCK_DIVIDER_PERIOD_COUNT_EN, P=2 for 65537 ticks -> period_count wraps to 1; disable holds the value.

Source files
------------

// File: rtl/clock_divider_pkg.sv
// rtl/clock_divider_pkg.sv - shared constants, config type and period clamp for clock_divider_bank
package clock_divider_pkg;

  localparam int          DEF_DIV_W  = 8;
  localparam int unsigned MIN_PERIOD = 2;

  typedef struct packed {
    logic [DEF_DIV_W-1:0] period;
    logic [DEF_DIV_W-1:0] high;
  } div_cfg_t;

  // Periods below two cycles cannot produce both a high and a low phase.
  function automatic int unsigned clamp_period(input int unsigned p);
    return (p < MIN_PERIOD) ? MIN_PERIOD : p;
  endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// rtl/clock_divider_channel.sv - one divider channel with shadowed config (CLOCK_DIVIDER_PERIOD_COUNT_EN adds a tick counter)
module clock_divider_channel
  import clock_divider_pkg::*;
#(
  parameter int DIV_W          = DEF_DIV_W,
  parameter int DEFAULT_PERIOD = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             restart_i,
  input  logic             cfg_we_i,
  input  logic [DIV_W-1:0] cfg_period_i,
  input  logic [DIV_W-1:0] cfg_high_i,
  output logic             pending_o,
  output logic             clk_out_o,
  output logic             tick_o
`ifdef CLOCK_DIVIDER_PERIOD_COUNT_EN
  ,
  output logic [15:0]      period_count_o
`endif
);

  typedef struct packed {
    logic [DIV_W-1:0] period;
    logic [DIV_W-1:0] high;
  } cfg_t;

  localparam cfg_t RST_CFG = '{period: DIV_W'(clamp_period(DEFAULT_PERIOD)),
                               high:   DIV_W'(DEFAULT_PERIOD / 2)};

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             run_q;
  cfg_t             act_q, act_d, sh_q;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             apply;

  // Outputs are computed from the next count so the flops line up with cnt_q.
  always_comb begin
    apply  = 1'b0;
    cnt_d  = cnt_q + DIV_W'(1);
    if (!enable_i || !run_q || restart_i || (cnt_q == act_q.period - DIV_W'(1))) begin
      cnt_d = '0;
      apply = pend_q;
    end
    act_d  = apply ? sh_q : act_q;
    pend_d = apply ? 1'b0 : (pend_q | cfg_we_i);
    clk_d  = enable_i && (cnt_d < act_d.high);
    tick_d = enable_i && (cnt_d == act_d.period - DIV_W'(1));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      run_q  <= 1'b0;
      act_q  <= RST_CFG;
      sh_q   <= RST_CFG;
      pend_q <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      run_q  <= enable_i;
      act_q  <= act_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      if (cfg_we_i) begin
        sh_q <= '{period: DIV_W'(clamp_period(32'(cfg_period_i))), high: cfg_high_i};
      end
    end
  end

`ifdef CLOCK_DIVIDER_PERIOD_COUNT_EN
  logic [15:0] pcnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pcnt_q <= '0;
    end else if (enable_i && tick_q) begin
      pcnt_q <= pcnt_q + 16'd1;
    end
  end

  assign period_count_o = pcnt_q;
`endif

  assign pending_o = pend_q;
  assign clk_out_o = clk_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/clock_divider_bank.sv
// rtl/clock_divider_bank.sv - multi-channel programmable clock divider (CLOCK_DIVIDER_PERIOD_COUNT_EN adds period_count)
module clock_divider_bank
  import clock_divider_pkg::*;
#(
  parameter  int CHANNELS       = 4,
  parameter  int DIV_W          = DEF_DIV_W,
  parameter  int DEFAULT_PERIOD = 10,
  localparam int CW             = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] enable,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CW-1:0]       cfg_chan,
  input  logic [DIV_W-1:0]    cfg_period,
  input  logic [DIV_W-1:0]    cfg_high,
  input  logic                sync_restart,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick
`ifdef CLOCK_DIVIDER_PERIOD_COUNT_EN
  ,
  output logic [CHANNELS*16-1:0] period_count
`endif
);

  localparam int NSEL = 1 << CW;

  logic [CHANNELS-1:0] pend;
  logic [NSEL-1:0]     pend_ext;

  // Unused channel codes read as never-pending, so requests to them are accepted and dropped.
  assign pend_ext  = NSEL'(pend);
  assign cfg_ready = !pend_ext[cfg_chan];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic cfg_we;
    assign cfg_we = cfg_valid && cfg_ready && (cfg_chan == CW'(i));

    clock_divider_channel #(
      .DIV_W          (DIV_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_chan (
      .clk_i          (clock),
      .rst_ni         (reset_n),
      .enable_i       (enable[i]),
      .restart_i      (sync_restart),
      .cfg_we_i       (cfg_we),
      .cfg_period_i   (cfg_period),
      .cfg_high_i     (cfg_high),
      .pending_o      (pend[i]),
      .clk_out_o      (clk_out[i]),
      .tick_o         (tick[i])
`ifdef CLOCK_DIVIDER_PERIOD_COUNT_EN
      ,
      .period_count_o (period_count[i*16 +: 16])
`endif
    );
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// tb/tb_clock_divider_bank.sv - directed bench for clock_divider_bank
module tb_clock_divider_bank;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] enable;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_chan;
  logic [7:0] cfg_period;
  logic [7:0] cfg_high;
  logic       sync_restart;
  logic [3:0] clk_out;
  logic [3:0] tick;
`ifdef CLOCK_DIVIDER_PERIOD_COUNT_EN
  logic [63:0] period_count;
`endif

  always #5 clock = ~clock;

  clock_divider_bank #(.CHANNELS(4), .DIV_W(8), .DEFAULT_PERIOD(10)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_chan     (cfg_chan),
    .cfg_period   (cfg_period),
    .cfg_high     (cfg_high),
    .sync_restart (sync_restart),
    .clk_out      (clk_out),
    .tick         (tick)
`ifdef CLOCK_DIVIDER_PERIOD_COUNT_EN
    ,
    .period_count (period_count)
`endif
  );

  typedef struct {
    logic [3:0] en;
    logic       v;
    logic [1:0] chan;
    logic [7:0] per;
    logic [7:0] hi;
    logic       rdy;
    logic [3:0] clk;
    logic [3:0] tk;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] en, input logic v, input logic [1:0] chan,
                     input logic [7:0] per, input logic [7:0] hi, input logic rdy,
                     input logic [3:0] clk, input logic [3:0] tk);
    vec_t r;
    r.en = en; r.v = v; r.chan = chan; r.per = per; r.hi = hi;
    r.rdy = rdy; r.clk = clk; r.tk = tk;
    vecs.push_back(r);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [3:0] en, input logic v, input logic [1:0] chan,
                       input logic [7:0] per, input logic [7:0] hi, input logic sr);
    enable = en; cfg_valid = v; cfg_chan = chan; cfg_period = per; cfg_high = hi;
    sync_restart = sr;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(4'b0000, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0);

    // ch0 only: defaults, mid-period reconfig, clamp, H=0, H>=P, disable/enable
    add(1, 0, 0, 0, 0, 1, 4'b0001, 0);
    for (int k = 1; k <= 8; k++) add(1, 0, 0, 0, 0, 1, (k < 5) ? 4'b0001 : 4'b0000, 0);
    add(1, 0, 0, 0, 0, 1, 0, 4'b0001);
    add(1, 0, 0, 0, 0, 1, 4'b0001, 0);
    add(1, 0, 0, 0, 0, 1, 4'b0001, 0);
    add(1, 1, 0, 4, 1, 1, 4'b0001, 0);
    add(1, 0, 0, 0, 0, 0, 4'b0001, 0);
    add(1, 0, 1, 0, 0, 1, 4'b0001, 0);
    for (int k = 0; k < 4; k++) add(1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 4'b0001);
    add(1, 0, 0, 0, 0, 0, 4'b0001, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0, 4'b0001);
    add(1, 0, 0, 0, 0, 1, 4'b0001, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0);
    add(1, 1, 0, 0, 1, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 4'b0001);
    add(1, 0, 0, 0, 0, 0, 4'b0001, 0);
    add(1, 0, 0, 0, 0, 1, 0, 4'b0001);
    add(1, 0, 0, 0, 0, 1, 4'b0001, 0);
    add(1, 0, 0, 0, 0, 1, 0, 4'b0001);
    add(1, 1, 0, 3, 0, 1, 4'b0001, 0);
    add(1, 0, 0, 0, 0, 0, 0, 4'b0001);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0, 4'b0001);
    add(1, 0, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0, 4'b0001);
    add(1, 1, 0, 6, 12, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 4'b0001);
    add(1, 0, 0, 0, 0, 0, 4'b0001, 0);
    for (int k = 0; k < 4; k++) add(1, 0, 0, 0, 0, 1, 4'b0001, 0);
    add(1, 0, 0, 0, 0, 1, 4'b0001, 4'b0001);
    add(1, 0, 0, 0, 0, 1, 4'b0001, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 1, 4'b0001, 0);
    add(1, 0, 0, 0, 0, 1, 4'b0001, 0);

    #12;
    chk("reset clk_out", clk_out, 0);
    chk("reset tick", tick, 0);
    chk("reset cfg_ready", cfg_ready, 1);
    step();
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].v, vecs[i].chan, vecs[i].per, vecs[i].hi, 1'b0);
      #1;
      chk($sformatf("vec%0d cfg_ready", i), cfg_ready, vecs[i].rdy);
      step();
      chk($sformatf("vec%0d clk_out", i), clk_out, vecs[i].clk);
      chk($sformatf("vec%0d tick", i), tick, vecs[i].tk);
    end

    // disabled channels apply their shadow on the next edge
    drive(4'b0000, 1'b1, 2'd0, 8'd3, 8'd2, 1'b0); step();
    drive(4'b0000, 1'b1, 2'd1, 8'd5, 8'd3, 1'b0); step();
    drive(4'b0000, 1'b1, 2'd2, 8'd7, 8'd4, 1'b0); step();
    drive(4'b0000, 1'b1, 2'd3, 8'd9, 8'd5, 1'b0); step();
    drive(4'b0000, 1'b0, 2'd3, 8'd0, 8'd0, 1'b0); #1;
    chk("disabled pending ready", cfg_ready, 0);
    step();
    chk("disabled applied ready", cfg_ready, 1);

    // sync_restart on the edge where ch0 would otherwise tick
    drive(4'b1111, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0); step();
    chk("start clk_out", clk_out, 4'b1111);
    step();
    chk("start+1 tick", tick, 0);
    sync_restart = 1'b1; step(); sync_restart = 1'b0;
    chk("restart clk_out", clk_out, 4'b1111);
    chk("restart tick", tick, 0);
    step();
    chk("restart+1 clk_out", clk_out, 4'b1111);
    step();
    chk("restart+2 clk_out", clk_out, 4'b1110);
    chk("restart+2 tick", tick, 4'b0001);
    drive(4'b1111, 1'b1, 2'd1, 8'd4, 8'd2, 1'b0); step();
    chk("restart+3 clk_out", clk_out, 4'b1101);
    drive(4'b1111, 1'b0, 2'd1, 8'd0, 8'd0, 1'b0); #1;
    chk("pre-reset ready ch1", cfg_ready, 0);

    // asynchronous reset with a pending config
    reset_n = 1'b0; #2;
    chk("async reset clk_out", clk_out, 0);
    chk("async reset tick", tick, 0);
    chk("async reset ready ch1", cfg_ready, 1);
    reset_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("post-reset cyc%0d clk_out", k), clk_out, (k <= 5) ? 4'b1111 : 4'b0000);
      chk($sformatf("post-reset cyc%0d tick", k), tick, (k == 10) ? 4'b1111 : 4'b0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
